// File: rtl/clz_scan_sequencer_if.sv
// Operand/result handshake bundle for clz_scan_sequencer.
// The slave modport is the sequencer. The master modport is the issuing and consuming logic.
interface clz_scan_sequencer_if #(
  parameter int WIDTH = 128,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             i_VALID;
  logic             o_READY;
  logic [WIDTH-1:0] i_DATA;
  logic             i_ABORT;
  logic             o_VALID;
  logic             i_READY;
  logic [CW-1:0]    o_COUNT;
  logic             o_ZERO;
  logic             o_BUSY;

  modport slave (
    input  i_VALID, i_DATA, i_ABORT, i_READY,
    output o_READY, o_VALID, o_COUNT, o_ZERO, o_BUSY
  );

  modport master (
    output i_VALID, i_DATA, i_ABORT, i_READY,
    input  o_READY, o_VALID, o_COUNT, o_ZERO, o_BUSY
  );
endinterface

// File: rtl/clz_scan_sequencer.sv
// Multi-cycle count-leading-zeros for wide operands.
// One shared 32-bit leading-zero stage scans the operand MSB-first, one chunk per cycle.
module clz_scan_sequencer #(
  parameter int WIDTH = 128,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic                 i_CLK,
  input logic                 i_RST_N,
  clz_scan_sequencer_if.slave bus
);
  localparam int CHUNKS = WIDTH / 32;
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    acc;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    count_q;
  logic             zero_q;
  logic             valid_q;

  // Shared 32-bit leading-zero stage: nibble zero detect, boundary nibble, in-nibble count.
  logic [31:0] chunk;
  logic [7:0]  nz;
  logic [2:0]  sel;
  logic [3:0]  nib;
  logic [1:0]  clz4;
  logic [4:0]  clz32;
  logic        chunk_zero;
  logic        accept;

  assign chunk = shreg[WIDTH-1 -: 32];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    nz  = '0;
    sel = '0;
    for (int i = 0; i < 8; i++) begin
      nz[i] = |chunk[4*i +: 4];
      if (nz[i]) sel = 3'(i);
    end
  end

  assign nib = chunk[{sel, 2'b00} +: 4];

  always_comb begin
    casez (nib)
      4'b1???: clz4 = 2'd0;
      4'b01??: clz4 = 2'd1;
      4'b001?: clz4 = 2'd2;
      default: clz4 = 2'd3;
    endcase
  end

  // Leading all-zero nibbles above the boundary nibble equal 7-sel, which is ~sel.
  assign clz32      = {~sel, 2'b00} + {3'b000, clz4};
  assign chunk_zero = ~|nz;
  assign accept     = (state == IDLE) && bus.i_VALID && !bus.i_ABORT;

  // NOTE: this datapath register is always loaded on accept before it is read, so it needs no reset.
  always_ff @(posedge i_CLK) begin
    if (accept) begin
      shreg <= bus.i_DATA;
    end else if (state == SCAN && chunk_zero) begin
      shreg <= shreg << 32;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.i_ABORT) begin
      state   <= IDLE;
      count_q <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_VALID) begin
            acc   <= '0;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!chunk_zero) begin
            count_q <= acc + CW'(clz32);
            zero_q  <= 1'b0;
            valid_q <= 1'b1;
            state   <= DONE;
          end else if (idx != IW'(CHUNKS - 1)) begin
            acc   <= acc + CW'(32);
            idx   <= idx + 1'b1;
          end else begin
            count_q <= acc + CW'(32);
            zero_q  <= 1'b1;
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.i_READY) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_READY = (state == IDLE);
  assign bus.o_BUSY  = (state != IDLE);
  assign bus.o_VALID = valid_q;
  assign bus.o_COUNT = count_q;
  assign bus.o_ZERO  = zero_q;
endmodule

// File: tb/tb_clz_scan_sequencer.sv
// Directed and random checks for clz_scan_sequencer at WIDTH=128.
// Expected counts, flags and latencies come from hand values or a bit-serial model.
module tb_clz_scan_sequencer;
  localparam int WIDTH = 128;
  localparam int CW    = $clog2(WIDTH + 1);

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  clz_scan_sequencer_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  clz_scan_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_clz(input logic [WIDTH-1:0] d);
    int n = 0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      if (d[b]) return n;
      n++;
    end
    return n;
  endfunction

  // Present an operand, wait for the result, compare it, then complete the output handshake.
  task automatic run_op(input logic [WIDTH-1:0] data, input int exp_lat, input int exp_cnt,
                        input logic exp_zero, input string tag);
    int lat = 0;
    bus.i_VALID = 1'b1;
    bus.i_DATA  = data;
    check({tag, "_ready"}, 32'(bus.o_READY), 32'd1);
    step();
    bus.i_VALID = 1'b0;
    bus.i_DATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
    while (!bus.o_VALID && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_count"}, 32'(bus.o_COUNT), 32'(exp_cnt));
    check({tag, "_zero"}, 32'(bus.o_ZERO), 32'(exp_zero));
    if (bus.o_VALID) begin
      bus.i_READY = 1'b1;
      step();
      bus.i_READY = 1'b0;
    end else begin
      bus.i_ABORT = 1'b1;
      step();
      bus.i_ABORT = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] d;
    int               j, n, zc;
    bit               held;

    rst_n       = 1'b0;
    bus.i_VALID = 1'b0;
    bus.i_DATA  = '0;
    bus.i_ABORT = 1'b0;
    bus.i_READY = 1'b0;
    #3;
    check("rst_ready", 32'(bus.o_READY), 32'd1);
    check("rst_valid", 32'(bus.o_VALID), 32'd0);
    check("rst_count", 32'(bus.o_COUNT), 32'd0);
    check("rst_zero",  32'(bus.o_ZERO),  32'd0);
    check("rst_busy",  32'(bus.o_BUSY),  32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    run_op(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1, 0, 1'b0, "msb");
    run_op(128'h0000_0000_0008_0000_0000_0000_0000_0000, 2, 44, 1'b0, "chunk1");
    run_op(128'h1, 4, 127, 1'b0, "lsb");
    run_op(128'h0, 4, 128, 1'b1, "allzero");
    run_op(128'h0000_0001_FFFF_FFFF_0000_0000_0000_0000, 1, 31, 1'b0, "chunk0_lsb");
    check("idle_after_op", 32'(bus.o_READY), 32'd1);

    // Backpressure: result must hold while the consumer stalls and inputs toggle.
    bus.i_VALID = 1'b1;
    bus.i_DATA  = 128'h0000_0000_0008_0000_0000_0000_0000_0000;
    step();
    bus.i_VALID = 1'b0;
    step();
    step();
    check("bp_valid_start", 32'(bus.o_VALID), 32'd1);
    held = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.i_VALID = c[0];
      bus.i_DATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      if (bus.o_VALID !== 1'b1 || bus.o_COUNT !== CW'(44) || bus.o_READY !== 1'b0) held = 1'b0;
    end
    check("bp_hold", 32'(held), 32'd1);
    check("bp_count", 32'(bus.o_COUNT), 32'd44);
    bus.i_READY = 1'b1;
    bus.i_VALID = 1'b1;
    bus.i_DATA  = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    step();
    bus.i_READY = 1'b0;
    check("bp_release_ready", 32'(bus.o_READY), 32'd1);
    check("bp_release_valid", 32'(bus.o_VALID), 32'd0);
    step();
    bus.i_VALID = 1'b0;
    check("bp_next_accept_busy", 32'(bus.o_BUSY), 32'd1);
    step();
    check("bp_next_valid", 32'(bus.o_VALID), 32'd1);
    check("bp_next_count", 32'(bus.o_COUNT), 32'd0);
    bus.i_READY = 1'b1;
    step();
    bus.i_READY = 1'b0;

    // Abort and valid together in IDLE: operand must not be taken.
    bus.i_VALID = 1'b1;
    bus.i_ABORT = 1'b1;
    bus.i_DATA  = 128'h1;
    step();
    bus.i_VALID = 1'b0;
    bus.i_ABORT = 1'b0;
    check("abort_idle_ready", 32'(bus.o_READY), 32'd1);
    check("abort_idle_busy",  32'(bus.o_BUSY),  32'd0);

    // Abort on the second scan cycle, starting from a non-zero held count.
    run_op(128'h1, 4, 127, 1'b0, "pre_abort");
    bus.i_VALID = 1'b1;
    bus.i_DATA  = 128'h0;
    step();
    bus.i_VALID = 1'b0;
    step();
    bus.i_ABORT = 1'b1;
    step();
    bus.i_ABORT = 1'b0;
    check("abort_ready", 32'(bus.o_READY), 32'd1);
    check("abort_count", 32'(bus.o_COUNT), 32'd0);
    check("abort_zero",  32'(bus.o_ZERO),  32'd0);
    held = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.o_VALID !== 1'b0) held = 1'b0;
      step();
    end
    check("abort_no_valid", 32'(held), 32'd1);

    // Asynchronous reset in the middle of a scan.
    run_op(128'h1, 4, 127, 1'b0, "pre_reset");
    bus.i_VALID = 1'b1;
    bus.i_DATA  = 128'h0;
    step();
    bus.i_VALID = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.o_READY), 32'd1);
    check("mid_rst_valid", 32'(bus.o_VALID), 32'd0);
    check("mid_rst_count", 32'(bus.o_COUNT), 32'd0);
    check("mid_rst_busy",  32'(bus.o_BUSY),  32'd0);
    step();
    rst_n = 1'b1;
    held = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.o_VALID !== 1'b0 || bus.o_READY !== 1'b1) held = 1'b0;
    end
    check("post_rst_idle", 32'(held), 32'd1);

    // Random sweep against the bit-serial model.
    for (int k = 0; k < 10000; k++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      j = $urandom_range(0, 3);
      for (int c = 0; c < j; c++) d[WIDTH - 1 - 32*c -: 32] = 32'h0;
      n  = ref_clz(d);
      zc = n / 32;
      if (zc > 3) zc = 3;
      run_op(d, zc + 1, n, (n == WIDTH), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
